// File: rtl/scaler_line_scheduler.sv
// Read-side line scheduler for the nearest-neighbour scaler's ring-buffer BRAM.
// Define SCALER_SCHED_STALL_CNT_EN to add the stall_cycles WAIT_LINE cycle counter.
module scaler_line_scheduler #(
  parameter int C_SRC_IMG_WIDTH  = 640,
  parameter int C_SRC_IMG_HEIGHT = 480,
  parameter int C_DST_IMG_WIDTH  = 1024,
  parameter int C_DST_IMG_HEIGHT = 768,
  parameter int C_X_RATIO        = 40960,
  parameter int C_Y_RATIO        = 40960,
  parameter int C_BUF_LINES_LOG2 = 2,
  parameter int C_ADDR_WIDTH     = 12
) (
  input  logic                    clk_in,
  input  logic                    rst,
  input  logic                    src_frame_start,
  input  logic                    src_line_done,
  output logic                    src_stall,
  input  logic                    dst_ready,
  output logic                    rd_en,
  output logic [C_ADDR_WIDTH-1:0] rd_addr,
  output logic                    post_img_vsync,
  output logic                    post_img_href,
  output logic                    frame_done
`ifdef SCALER_SCHED_STALL_CNT_EN
  ,
  output logic [15:0]             stall_cycles
`endif
);

  localparam int          COL_W     = C_ADDR_WIDTH - C_BUF_LINES_LOG2;
  localparam logic [10:0] SRC_H_MAX = 11'(C_SRC_IMG_HEIGHT);
  localparam logic [11:0] SY_LIM    = 12'(C_SRC_IMG_HEIGHT - 1);
  localparam logic [11:0] SX_LIM    = 12'(C_SRC_IMG_WIDTH - 1);
  localparam logic [15:0] X_LAST    = 16'(C_DST_IMG_WIDTH - 1);
  localparam logic [15:0] Y_LAST    = 16'(C_DST_IMG_HEIGHT - 1);
  localparam logic [26:0] X_STEP    = 27'(C_X_RATIO);
  localparam logic [26:0] Y_STEP    = 27'(C_Y_RATIO);
  localparam logic [11:0] BUF_LINES = 12'(1 << C_BUF_LINES_LOG2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CALC,
    S_WAIT_LINE,
    S_ROW,
    S_ROW_END,
    S_DONE
  } state_t;

  state_t      state;
  logic [10:0] lines_wr;
  logic [26:0] y_acc;
  logic [26:0] x_acc;
  logic [15:0] y_cnt;
  logic [15:0] x_cnt;
  logic [10:0] sy_p0;

  // acc_hi is accumulator bits [26:15]: integer part plus the half bit for rounding.
  function automatic logic [10:0] round_sat(input logic [11:0] acc_hi, input logic [11:0] lim);
    logic [11:0] r;
    r = {1'b0, acc_hi[11:1]} + {11'd0, acc_hi[0]};
    return (r > lim) ? lim[10:0] : r[10:0];
  endfunction

  assign src_stall = (state != S_IDLE) && ({1'b0, lines_wr} >= ({1'b0, sy_p0} + BUF_LINES));

  always_ff @(posedge clk_in) begin
    if (rst) begin
      lines_wr <= '0;
    end else if (src_frame_start) begin
      lines_wr <= '0;
    end else if (src_line_done && (lines_wr != SRC_H_MAX)) begin
      lines_wr <= lines_wr + 11'd1;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state          <= S_IDLE;
      y_acc          <= '0;
      x_acc          <= '0;
      y_cnt          <= '0;
      x_cnt          <= '0;
      sy_p0          <= '0;
      rd_en          <= 1'b0;
      rd_addr        <= '0;
      post_img_href  <= 1'b0;
      post_img_vsync <= 1'b0;
      frame_done     <= 1'b0;
    end else begin
      frame_done    <= 1'b0;
      post_img_href <= rd_en;
      // vsync opens with the first pixel and closes when a fresh frame (or abort) recalculates row 0
      if (rd_en) begin
        post_img_vsync <= 1'b1;
      end else if ((state == S_CALC) && (y_cnt == '0)) begin
        post_img_vsync <= 1'b0;
      end

      if (src_frame_start) begin
        state <= S_CALC;
        y_acc <= '0;
        y_cnt <= '0;
        x_acc <= '0;
        x_cnt <= '0;
        sy_p0 <= '0;
        rd_en <= 1'b0;
      end else begin
        case (state)
          S_IDLE: begin
          end
          S_CALC: begin
            sy_p0 <= round_sat(y_acc[26:15], SY_LIM);
            state <= S_WAIT_LINE;
          end
          S_WAIT_LINE: begin
            if ((lines_wr > sy_p0) && dst_ready) begin
              rd_en   <= 1'b1;
              rd_addr <= {sy_p0[C_BUF_LINES_LOG2-1:0], {COL_W{1'b0}}};
              x_acc   <= X_STEP;
              x_cnt   <= '0;
              state   <= S_ROW;
            end
          end
          S_ROW: begin
            // x_acc already holds the accumulator for the next column
            if (x_cnt == X_LAST) begin
              rd_en <= 1'b0;
              state <= S_ROW_END;
            end else begin
              rd_addr <= {sy_p0[C_BUF_LINES_LOG2-1:0], COL_W'(round_sat(x_acc[26:15], SX_LIM))};
              x_acc   <= x_acc + X_STEP;
              x_cnt   <= x_cnt + 16'd1;
            end
          end
          S_ROW_END: begin
            y_cnt <= y_cnt + 16'd1;
            y_acc <= y_acc + Y_STEP;
            if (y_cnt == Y_LAST) begin
              frame_done     <= 1'b1;
              post_img_vsync <= 1'b0;
              state          <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
          S_DONE: begin
            state <= S_IDLE;
          end
          default: begin
            state <= S_IDLE;
          end
        endcase
      end
    end
  end

`ifdef SCALER_SCHED_STALL_CNT_EN
  always_ff @(posedge clk_in) begin
    if (rst || src_frame_start) begin
      stall_cycles <= '0;
    end else if ((state == S_WAIT_LINE) && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_scaler_line_scheduler.sv
// Directed bench for scaler_line_scheduler using reduced image sizes (20x10 -> 32x16, ratio 0.625).
module tb_scaler_line_scheduler;

  localparam int SRC_W = 20;
  localparam int SRC_H = 10;
  localparam int DST_W = 32;
  localparam int DST_H = 16;
  localparam int X_R   = 40960;
  localparam int Y_R   = 40960;

  logic        clk_in;
  logic        rst;
  logic        src_frame_start;
  logic        src_line_done;
  logic        src_stall;
  logic        dst_ready;
  logic        rd_en;
  logic [11:0] rd_addr;
  logic        post_img_vsync;
  logic        post_img_href;
  logic        frame_done;
`ifdef SCALER_SCHED_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  scaler_line_scheduler #(
    .C_SRC_IMG_WIDTH (SRC_W),
    .C_SRC_IMG_HEIGHT(SRC_H),
    .C_DST_IMG_WIDTH (DST_W),
    .C_DST_IMG_HEIGHT(DST_H),
    .C_X_RATIO       (X_R),
    .C_Y_RATIO       (Y_R),
    .C_BUF_LINES_LOG2(2),
    .C_ADDR_WIDTH    (12)
  ) dut (
    .clk_in         (clk_in),
    .rst            (rst),
    .src_frame_start(src_frame_start),
    .src_line_done  (src_line_done),
    .src_stall      (src_stall),
    .dst_ready      (dst_ready),
    .rd_en          (rd_en),
    .rd_addr        (rd_addr),
    .post_img_vsync (post_img_vsync),
    .post_img_href  (post_img_href),
    .frame_done     (frame_done)
`ifdef SCALER_SCHED_STALL_CNT_EN
    ,
    .stall_cycles   (stall_cycles)
`endif
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  typedef struct {
    logic        fs;
    logic        ld;
    logic        dr;
    logic        rd_en;
    logic        href;
    logic        vsync;
    logic        stall;
    logic        fd;
    logic [11:0] addr;
  } vec_t;

  vec_t        vecs[9];
  int          checks = 0;
  int          errors = 0;
  int          href_cnt = 0;
  int          fd_cnt = 0;
  int          lines_fed = 0;
  int          fd_snap;
  logic [11:0] last_addr;

  always @(posedge clk_in) begin
    if (!rst) begin
      if (post_img_href) href_cnt <= href_cnt + 1;
      if (frame_done)    fd_cnt   <= fd_cnt + 1;
    end
  end

  function automatic int exp_sy(input int r);
    int v;
    v = (r * Y_R + 32768) / 65536;
    return (v > SRC_H - 1) ? SRC_H - 1 : v;
  endfunction

  function automatic int exp_addr(input int r, input int c);
    int sx;
    sx = (c * X_R + 32768) / 65536;
    if (sx > SRC_W - 1) sx = SRC_W - 1;
    return (exp_sy(r) % 4) * 1024 + sx;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic step(input logic fs, input logic ld, input logic dr);
    src_frame_start = fs;
    src_line_done   = ld;
    dst_ready       = dr;
    @(posedge clk_in);
    @(negedge clk_in);
    src_frame_start = 1'b0;
    src_line_done   = 1'b0;
  endtask

  task automatic wait_rd_en(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (rd_en) break;
      step(1'b0, 1'b0, 1'b1);
    end
    check("wait_rd_en", int'(rd_en), 1);
  endtask

  task automatic read_cols(input int r, input int c0, input int c1);
    int bad;
    bad = 0;
    for (int c = c0; c <= c1; c++) begin
      if (rd_en !== 1'b1 || rd_addr !== 12'(exp_addr(r, c))) bad++;
      last_addr = rd_addr;
      if (c < c1) step(1'b0, 1'b0, 1'b1);
    end
    check($sformatf("row%0d_addrs", r), bad, 0);
  endtask

  task automatic full_row(input int r);
    read_cols(r, 0, DST_W - 1);
    step(1'b0, 1'b0, 1'b1);
    check($sformatf("row%0d_len", r), int'(rd_en), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    //                fs    ld    dr    rd_en href  vsync stall fd    addr
    vecs[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0};
    vecs[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0};
    vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 12'd0};
    vecs[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd1};
    vecs[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd2};
    vecs[8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 12'd3};

    rst = 1'b1;
    src_frame_start = 1'b0;
    src_line_done = 1'b0;
    dst_ready = 1'b0;
    repeat (3) @(posedge clk_in);
    @(negedge clk_in);
    check("reset_rd_en", int'(rd_en), 0);
    check("reset_rd_addr", int'(rd_addr), 0);
    check("reset_href", int'(post_img_href), 0);
    check("reset_vsync", int'(post_img_vsync), 0);
    check("reset_frame_done", int'(frame_done), 0);
    check("reset_stall", int'(src_stall), 0);
    rst = 1'b0;

    // Frame 1: table covers start, hold while dst_ready=0, and the first columns of row 0
    for (int i = 0; i < 9; i++) begin
      step(vecs[i].fs, vecs[i].ld, vecs[i].dr);
      check($sformatf("vec%0d", i),
            int'({rd_en, post_img_href, post_img_vsync, src_stall, frame_done, rd_addr}),
            int'({vecs[i].rd_en, vecs[i].href, vecs[i].vsync, vecs[i].stall, vecs[i].fd, vecs[i].addr}));
    end
    lines_fed = 1;
    step(1'b0, 1'b0, 1'b1);
    read_cols(0, 5, DST_W - 1);
    check("row0_last_addr", int'(last_addr), 19);
    step(1'b0, 1'b0, 1'b1);
    check("row0_len", int'(rd_en), 0);

    // Row 1 needs source line 1, which is not yet resident
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (rd_en !== 1'b0) bad++;
    end
    check("row1_blocked", bad, 0);
    step(1'b0, 1'b1, 1'b1);
    lines_fed = 2;
    wait_rd_en(8);
    check("row1_first_addr", int'(rd_addr), 1024);
    full_row(1);
    wait_rd_en(8);
    check("row2_first_addr", int'(rd_addr), 1024);
    full_row(2);
    for (int r = 3; r < DST_H; r++) begin
      while (lines_fed <= exp_sy(r)) begin
        step(1'b0, 1'b1, 1'b1);
        lines_fed++;
      end
      wait_rd_en(8);
      full_row(r);
    end
    check("last_addr", int'(last_addr), 3 * 0 + 1024 + 19);
    check("end_href", int'(post_img_href), 1);
    check("end_vsync_before", int'(post_img_vsync), 1);
    check("end_fd_before", int'(frame_done), 0);
    step(1'b0, 1'b0, 1'b1);
    check("end_fd_pulse", int'(frame_done), 1);
    check("end_vsync_fall", int'(post_img_vsync), 0);
    check("end_href_fall", int'(post_img_href), 0);
    step(1'b0, 1'b0, 1'b1);
    check("end_fd_single", int'(frame_done), 0);
    check("frame_href_cycles", href_cnt, DST_W * DST_H);
    check("frame_done_count", fd_cnt, 1);

    // Frame 2: writer back-pressure while row 0 is still pending
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b0);
    check("stall_at_3_lines", int'(src_stall), 0);
    step(1'b0, 1'b1, 1'b0);
    check("stall_at_4_lines", int'(src_stall), 1);
    check("stall_no_read", int'(rd_en), 0);
    wait_rd_en(4);
    full_row(0);
    check("stall_hold_row_end", int'(src_stall), 1);
    step(1'b0, 1'b0, 1'b0);
    check("stall_hold_calc", int'(src_stall), 1);
    step(1'b0, 1'b0, 1'b0);
    check("stall_release_sy1", int'(src_stall), 0);
    for (int r = 1; r < 5; r++) begin
      wait_rd_en(8);
      full_row(r);
    end

    // Abort in the middle of row 5
    wait_rd_en(8);
    read_cols(5, 0, 9);
    fd_snap = fd_cnt;
    step(1'b1, 1'b0, 1'b1);
    check("abort_rd_en", int'(rd_en), 0);
    check("abort_href_lag", int'(post_img_href), 1);
    check("abort_vsync_lag", int'(post_img_vsync), 1);
    step(1'b0, 1'b0, 1'b1);
    check("abort_href_fall", int'(post_img_href), 0);
    check("abort_vsync_fall", int'(post_img_vsync), 0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 1'b1);
      if (rd_en !== 1'b0 || frame_done !== 1'b0) bad++;
    end
    check("abort_lines_cleared", bad, 0);
    check("abort_no_frame_done", fd_cnt - fd_snap, 0);
    check("abort_stall", int'(src_stall), 0);
    step(1'b0, 1'b1, 1'b1);
    wait_rd_en(8);
    check("abort_restart_addr", int'(rd_addr), 0);
    full_row(0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
